// File: rtl/tree_path_sequencer.sv
// Mixed-radix leaf-path enumerator: one tuple per valid/ready transfer, IDLE -> RUN -> DONE.
// Optional registered path_parity output when TREE_PATH_PARITY_EN is defined.
module tree_path_sequencer #(
  parameter int unsigned LEVELS      = 10,
  parameter int unsigned DIGIT_W     = 3,
  parameter int unsigned FANOUT_TOP  = 3,
  parameter int unsigned FANOUT_LEAF = 5,
  parameter int unsigned IDX_W       = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LEVELS*DIGIT_W-1:0]   path,
  output logic [IDX_W-1:0]            leaf_index,
  output logic                        last,
  output logic                        busy,
  output logic                        done
`ifdef TREE_PATH_PARITY_EN
  ,
  output logic                        path_parity
`endif
);

  localparam int unsigned PW = LEVELS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] TOP_MAX  = DIGIT_W'(FANOUT_TOP - 1);
  localparam logic [DIGIT_W-1:0] LEAF_MAX = DIGIT_W'(FANOUT_LEAF - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     path_q, path_d;
  logic [IDX_W-1:0]  leaf_index_q, leaf_index_d;
  logic              last_q, last_d;
  logic              xfer;

  function automatic logic [PW-1:0] inc_path(input logic [PW-1:0] p);
    logic               carry;
    logic [DIGIT_W-1:0] dig;
    logic [DIGIT_W-1:0] lim;
    int unsigned        d;
    inc_path = p;
    carry    = 1'b1;
    // Leaf digit is least significant, so walk from LEVELS-1 down to 0.
    for (int unsigned i = 0; i < LEVELS; i++) begin
      d   = LEVELS - 1 - i;
      dig = p[d*DIGIT_W +: DIGIT_W];
      lim = (d == LEVELS - 1) ? LEAF_MAX : TOP_MAX;
      if (carry) begin
        if (dig == lim) begin
          dig = '0;
        end else begin
          dig   = dig + 1'b1;
          carry = 1'b0;
        end
      end
      inc_path[d*DIGIT_W +: DIGIT_W] = dig;
    end
  endfunction

  function automatic logic all_max(input logic [PW-1:0] p);
    all_max = 1'b1;
    for (int unsigned i = 0; i < LEVELS; i++) begin
      if (p[i*DIGIT_W +: DIGIT_W] != ((i == LEVELS - 1) ? LEAF_MAX : TOP_MAX))
        all_max = 1'b0;
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      path_q       <= '0;
      leaf_index_q <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      path_q       <= path_d;
      leaf_index_q <= leaf_index_d;
      last_q       <= last_d;
    end
  end

  assign xfer = (state_q == S_RUN) && out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (xfer && last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    path_d       = path_q;
    leaf_index_d = leaf_index_q;
    if ((state_q == S_IDLE) && start) begin
      path_d       = '0;
      leaf_index_d = '0;
    end else if (xfer && !last_q) begin
      path_d       = inc_path(path_q);
      leaf_index_d = leaf_index_q + 1'b1;
    end
    // last is precomputed from the next path so it lines up with the registered tuple.
    last_d = (state_d == S_RUN) && all_max(path_d);
  end

  always_comb begin
    out_valid  = (state_q == S_RUN);
    busy       = (state_q == S_RUN);
    done       = (state_q == S_DONE);
    path       = path_q;
    leaf_index = leaf_index_q;
    last       = last_q;
  end

`ifdef TREE_PATH_PARITY_EN
  logic path_parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) path_parity_q <= 1'b0;
    else     path_parity_q <= ^path_d;
  end

  assign path_parity = path_parity_q;
`endif

endmodule

// File: tb/tb_tree_path_sequencer.sv
// Bench for tree_path_sequencer: small 3x3x5 instance under directed/random handshakes
// plus a default-parameter instance swept end to end in parallel.
module tb_tree_path_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  // small instance: LEVELS=3, FANOUT_TOP=3, FANOUT_LEAF=5
  logic        s_start, s_ready, s_valid, s_last, s_busy, s_done;
  logic [8:0]  s_path;
  logic [7:0]  s_idx;
  logic        s_par;

  // default-parameter instance
  logic        b_start, b_ready, b_valid, b_last, b_busy, b_done;
  logic [29:0] b_path;
  logic [19:0] b_idx;
  logic        b_par;

  tree_path_sequencer #(
    .LEVELS(3), .DIGIT_W(3), .FANOUT_TOP(3), .FANOUT_LEAF(5), .IDX_W(8)
  ) u_small (
    .clk(clk), .rst(rst), .start(s_start), .out_valid(s_valid), .out_ready(s_ready),
    .path(s_path), .leaf_index(s_idx), .last(s_last), .busy(s_busy), .done(s_done)
`ifdef TREE_PATH_PARITY_EN
    , .path_parity(s_par)
`endif
  );

  tree_path_sequencer u_big (
    .clk(clk), .rst(rst), .start(b_start), .out_valid(b_valid), .out_ready(b_ready),
    .path(b_path), .leaf_index(b_idx), .last(b_last), .busy(b_busy), .done(b_done)
`ifdef TREE_PATH_PARITY_EN
    , .path_parity(b_par)
`endif
  );

`ifndef TREE_PATH_PARITY_EN
  assign s_par = 1'b0;
  assign b_par = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Tuple for ordinal idx: leaf digit is idx mod FANOUT_LEAF, then top digits in base FANOUT_TOP.
  function automatic logic [29:0] model_path(input int unsigned idx, input int unsigned levels,
                                             input int unsigned ft, input int unsigned fl);
    int unsigned r;
    logic [29:0] p;
    p = '0;
    r = idx;
    p[(levels-1)*3 +: 3] = 3'(r % fl);
    r = r / fl;
    for (int k = int'(levels) - 2; k >= 0; k--) begin
      p[k*3 +: 3] = 3'(r % ft);
      r = r / ft;
    end
    return p;
  endfunction

  // ---------------- default-parameter sweep monitor ----------------
  int unsigned b_cnt    = 0;
  int unsigned b_done_n = 0;
  logic [29:0] b_final_path = '0;
  logic [19:0] b_final_idx  = '0;

  always @(negedge clk) begin
    logic [29:0] bp;
    if (b_valid) begin
      bp = model_path(b_cnt, 10, 3, 5);
      chk("big_path", b_path, bp);
      chk("big_index", b_idx, b_cnt);
      chk("big_last", b_last, b_cnt == 98414);
`ifdef TREE_PATH_PARITY_EN
      chk("big_parity", b_par, ^bp);
`endif
      if (b_last) begin
        b_final_path = b_path;
        b_final_idx  = b_idx;
      end
      b_cnt++;
    end
    if (b_done) b_done_n++;
  end

  // ---------------- small-instance sweep ----------------
  int unsigned sw_cycles;
  int unsigned sw_xfers;

  task automatic run_sweep(input bit rand_ready, input bit poke_start);
    int unsigned idx = 0;
    int unsigned cyc = 0;
    bit fin = 1'b0;
    bit rdy;
    logic [29:0] ep;
    sw_xfers = 0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    while (!fin && cyc < 1000) begin
      cyc++;
      ep = model_path(idx, 3, 3, 5);
      chk("valid", s_valid, 1);
      chk("busy", s_busy, 1);
      chk("done_in_run", s_done, 0);
      chk("path", s_path, ep[8:0]);
      chk("index", s_idx, idx);
      chk("last", s_last, idx == 44);
`ifdef TREE_PATH_PARITY_EN
      chk("parity", s_par, ^ep[8:0]);
`endif
      rdy     = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      s_ready = rdy;
      s_start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (rdy) begin
        sw_xfers++;
        if (idx == 44) fin = 1'b1;
        else idx++;
      end
    end
    sw_cycles = cyc;
    chk("sweep_finished", fin, 1);
    chk("done_pulse", s_done, 1);
    chk("valid_in_done", s_valid, 0);
    chk("busy_in_done", s_busy, 0);
    s_start = poke_start;
    s_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    s_start = 1'b0;
    chk("done_cleared", s_done, 0);
    chk("idle_valid", s_valid, 0);
    chk("idle_busy", s_busy, 0);
  endtask

  logic [29:0] exp_final;

  initial begin
    int unsigned guard;
    rst = 1'b1; s_start = 1'b0; s_ready = 1'b0; b_start = 1'b0; b_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", s_valid, 0);
    chk("rst_path", s_path, 0);
    chk("rst_index", s_idx, 0);
    chk("rst_last", s_last, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_parity", s_par, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", s_valid, 0);

    // reset asserted mid-sweep while a handshake is pending
    s_start = 1'b1; s_ready = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_index", s_idx, 7);
    rst = 1'b1;
    #1;
    chk("midrst_valid", s_valid, 0);
    chk("midrst_path", s_path, 0);
    chk("midrst_index", s_idx, 0);
    chk("midrst_busy", s_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("no_replay_valid", s_valid, 0);
    chk("no_replay_path", s_path, 0);

    // launch the default-parameter sweep; its monitor runs alongside the rest
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;

    run_sweep(1'b0, 1'b0);
    chk("full_rate_cycles", sw_cycles, 45);
    chk("full_rate_xfers", sw_xfers, 45);

    run_sweep(1'b1, 1'b0);
    chk("rand_ready_xfers", sw_xfers, 45);

    run_sweep(1'b1, 1'b1);
    chk("start_noise_xfers", sw_xfers, 45);

    // restart immediately in the IDLE cycle after done
    run_sweep(1'b0, 1'b0);
    chk("restart_xfers", sw_xfers, 45);

    guard = 0;
    while (b_done_n == 0 && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    chk("big_done_seen", b_done_n, 1);
    repeat (3) @(negedge clk);
    exp_final = '0;
    for (int k = 0; k < 9; k++) exp_final[k*3 +: 3] = 3'd2;
    exp_final[27 +: 3] = 3'd4;
    chk("big_transfers", b_cnt, 98415);
    chk("big_final_path", b_final_path, exp_final);
    chk("big_final_index", b_final_idx, 98414);
    chk("big_done_count", b_done_n, 1);
    chk("big_idle_valid", b_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
